dot_product_accumulator: RTL
============================

DOT_PRODUCT_ACCUMULATOR -- requirements
Module: dot_product_accumulator

Interface
REQ-001 Parameter ACC_W, default 24: accumulator and result width in bits; legal range 16..32.
REQ-002 Parameter MAX_TERMS, default 16: maximum terms per vector; legal range 2..256.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: operand pair present.
REQ-006 Port in_ready, output, 1: block accepts the operand pair this cycle.
REQ-007 Port in_a, input, 8: unsigned multiplicand.
REQ-008 Port in_b, input, 8: unsigned multiplier.
REQ-009 Port in_last, input, 1: final term of the current vector.
REQ-010 Port out_valid, output, 1: result present.
REQ-011 Port out_ready, input, 1: consumer accepts the result.
REQ-012 Port out_sum, output, ACC_W: sum of in_a*in_b over the vector.
REQ-013 Port out_count, output, 9: number of terms in the vector.
REQ-014 Port out_ovf, output, 1: accumulator overflow occurred in the vector.

Function
REQ-015 An input is accepted when in_valid and in_ready are both high on a rising edge.
REQ-016 The FSM SHALL have states IDLE (no terms held), ACCUM (at least one term accepted, no end seen) and DONE (result held).
REQ-017 Stage 1 SHALL register the 16-bit unsigned product one cycle after acceptance; stage 2 SHALL add the zero-extended product to the accumulator one cycle later.
REQ-018 If in_last is accepted at edge T, out_valid SHALL rise at edge T+2, with the last product included in out_sum.
REQ-019 Accepting the term that makes the count reach MAX_TERMS SHALL end the vector exactly as if in_last were high.
REQ-020 Acceptance SHALL drive IDLE to ACCUM, or to the end-pending condition if the term ends the vector.
REQ-021 in_ready SHALL be low from the edge after the ending term is accepted until the edge on which the result handshake completes.
REQ-022 out_valid, out_sum, out_count and out_ovf SHALL hold stable while out_valid is high and out_ready is low.
REQ-023 On the out_valid & out_ready edge, the block SHALL clear the accumulator, count and ovf, go to IDLE, and raise in_ready.
REQ-024 in_valid while in_ready is low SHALL be ignored with no state change.
REQ-025 A carry out of bit ACC_W-1 SHALL set the sticky out_ovf for the current vector.
REQ-026 out_count SHALL equal the number of accepted terms, 1..MAX_TERMS.

Reset
REQ-027 On rst, the block SHALL enter IDLE, clear both pipeline stages, accumulator and count, and drive in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
REQ-028 rst asserted mid-vector or while DONE SHALL discard all partial and held results.
REQ-029 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-030 With macro DPA_SATURATE_EN defined, overflow SHALL clamp the accumulator to all-ones for the rest of the vector and set out_ovf.
REQ-031 Without DPA_SATURATE_EN, the accumulator SHALL wrap modulo 2^ACC_W and set out_ovf.

Structure
REQ-032 Package dpa_pkg SHALL hold the FSM state enum, the 8-bit operand and 16-bit product widths, and the 9-bit count width.
REQ-033 One sub-module, dpa_mult8, SHALL provide the combinational 8x8 unsigned product feeding stage 1.

Verification
REQ-034 Single term 255,255 with in_last, ACC_W=24 -> out_valid two edges later; out_sum=65025, out_count=1, out_ovf=0.
REQ-035 Terms (1,1),(2,2),(3,3),(4,4) back-to-back, last on the fourth -> out_sum=30, out_count=4; in_ready low until the result handshake.
REQ-036 out_ready held low 5 cycles after out_valid -> outputs stable, in_valid ignored; handshake on cycle 6 -> in_ready=1 on the next edge.
REQ-037 ACC_W=16, terms (255,255)x2 -> out_ovf=1; out_sum=64514 without DPA_SATURATE_EN, 65535 with it.
REQ-038 16 terms of (1,1) with in_last never asserted, MAX_TERMS=16 -> out_sum=16, out_count=16.
REQ-039 rst asserted after 3 accepted terms, then (2,3) with in_last -> out_sum=6, out_count=1.

Source files
------------

// File: rtl/dpa_pkg.sv
// Shared widths and FSM encoding for the dot-product accumulator.
// Pure declarations: no logic, no latency, no flow control.
package dpa_pkg;
   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   localparam int CNT_W  = 9;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } dpa_state_e;
endpackage

// File: rtl/dpa_mult8.sv
// Combinational 8x8 unsigned multiplier feeding the product register.
// Zero latency; no flow control, the caller qualifies the result.
module dpa_mult8
   import dpa_pkg::*;
(
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   output logic [PROD_W-1:0] p_o
);
   assign p_o = PROD_W'(a_i) * PROD_W'(b_i);
endmodule

// File: rtl/dot_product_accumulator.sv
// Two-stage multiply-accumulate over a vector; result valid two edges after the ending term.
// in_ready drops from ending term until result handshake; DPA_SATURATE_EN selects clamp-on-overflow.
module dot_product_accumulator
   import dpa_pkg::*;
#(
   parameter int ACC_W     = 24,
   parameter int MAX_TERMS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   dpa_state_e          state_q, state_d;
   logic [PROD_W-1:0]   prod_q, prod_d;
   logic                prod_vld_q, prod_vld_d;
   logic                prod_last_q, prod_last_d;
   logic                last2_q, last2_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                end_pend_q, end_pend_d;

   logic [PROD_W-1:0]   mult_p;
   logic                accept;
   logic                ends_vec;
   logic                out_fire;
   logic [CNT_W-1:0]    cnt_inc;
   logic [ACC_W:0]      sum_ext;

   dpa_mult8 u_mult (
      .a_i (in_a),
      .b_i (in_b),
      .p_o (mult_p)
   );

   assign in_ready  = (state_q != S_DONE) && !end_pend_q;
   assign out_valid = (state_q == S_DONE);
   assign out_sum   = acc_q;
   assign out_count = count_q;
   assign out_ovf   = ovf_q;

   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign cnt_inc  = count_q + CNT_W'(1);
   assign ends_vec = in_last || (cnt_inc == MAX_CNT);
   assign sum_ext  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};

   always_comb begin
      state_d     = state_q;
      prod_d      = prod_q;
      prod_vld_d  = accept;
      prod_last_d = accept && ends_vec;
      last2_d     = prod_vld_q && prod_last_q;
      acc_d       = acc_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      end_pend_d  = end_pend_q;

      if (accept) begin
         prod_d  = mult_p;
         count_d = cnt_inc;
         if (ends_vec) end_pend_d = 1'b1;
      end

      if (prod_vld_q) begin
`ifdef DPA_SATURATE_EN
         // Once clamped, stay pinned at all-ones until the vector is consumed.
         if (ovf_q || sum_ext[ACC_W]) acc_d = '1;
         else                         acc_d = sum_ext[ACC_W-1:0];
`else
         acc_d = sum_ext[ACC_W-1:0];
`endif
         if (sum_ext[ACC_W]) ovf_d = 1'b1;
      end

      case (state_q)
         S_IDLE:  if (accept) state_d = S_ACCUM;
         S_ACCUM: if (last2_q) state_d = S_DONE;
         S_DONE: begin
            if (out_fire) begin
               state_d    = S_IDLE;
               acc_d      = '0;
               count_d    = '0;
               ovf_d      = 1'b0;
               end_pend_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         prod_q      <= '0;
         prod_vld_q  <= 1'b0;
         prod_last_q <= 1'b0;
         last2_q     <= 1'b0;
         acc_q       <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         end_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         prod_q      <= prod_d;
         prod_vld_q  <= prod_vld_d;
         prod_last_q <= prod_last_d;
         last2_q     <= last2_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         end_pend_q  <= end_pend_d;
      end
   end
endmodule
